// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan driver.
//   seg_t               - 7-bit segment vector, bit 0 = a .. bit 6 = g
//   DEFAULT_REFRESH_DIV - clk cycles each digit stays enabled by default
//   SEG_BLANK           - all segments off (active-high)
//   HEX_SEG_TABLE       - hex digit to active-high gfedcba pattern, index = nibble
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam int   DEFAULT_REFRESH_DIV = 50000;
  localparam seg_t SEG_BLANK           = 7'b000_0000;

  // Entry 0 is the rightmost element: 0 1 2 3 4 5 6 7 8 9 A b C d E F
  localparam seg_t [15:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: groups the value/load inputs and display outputs of the
// scan driver.
//   data_in, load, dp_in, blank_zeros - driven by the producer (master)
//   seg, dp, an, frame_done           - driven by the scan driver (slave)
interface seg7_scan_driver_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 4
) ();

  logic [DATA_WIDTH-1:0] data_in;
  logic                  load;
  logic [DIGITS-1:0]     dp_in;
  logic                  blank_zeros;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;

  modport master (
    output data_in, load, dp_in, blank_zeros,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  data_in, load, dp_in, blank_zeros,
    output seg, dp, an, frame_done
  );

endinterface

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to 7-segment decode.
//   nibble_i - hex value 0..F
//   blank_i  - 1 forces all segments off
//   seg_o    - segments a..g (bit 0 = a), polarity set by ACTIVE_LOW
module hex_to_seg7
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output seg_t       seg_o
);

  seg_t seg_high;

  always_comb begin
    seg_high = blank_i ? SEG_BLANK : HEX_SEG_TABLE[nibble_i];
    seg_o    = ACTIVE_LOW ? ~seg_high : seg_high;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode 7-segment display driver.
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset
//   bus   - slave side of seg7_scan_driver_if:
//           data_in/dp_in/load fill a holding register that reaches the
//           display only at frame boundaries; blank_zeros enables
//           leading-zero blanking; seg/dp/an/frame_done are registered.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input logic              clk,
  input logic              reset,
  seg7_scan_driver_if.slave bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PRESCALE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]     INDEX_LAST    = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] DIGIT0_HOT    = DIGITS'(1);
  localparam logic [DIGITS-1:0] AN_RESET      = ACTIVE_LOW ? ~DIGIT0_HOT : DIGIT0_HOT;
  localparam seg_t              SEG_RESET     = ACTIVE_LOW ? ~HEX_SEG_TABLE[0] : HEX_SEG_TABLE[0];
  localparam logic              DP_RESET      = ACTIVE_LOW;

  logic [PW-1:0]         prescale_q, prescale_d;
  logic [IW-1:0]         index_q, index_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, disp_q, disp_d;
  logic [DIGITS-1:0]     hold_dp_q, hold_dp_d, disp_dp_q, disp_dp_d;
  logic                  pending_q, pending_d;
  logic [DIGITS-1:0]     an_q, an_d;
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;

  logic tick;
  logic wrap;

  assign tick = (prescale_q == PRESCALE_LAST);
  assign wrap = tick && (index_q == INDEX_LAST);

  // Refresh prescaler and digit index.
  always_comb begin
    prescale_d = tick ? '0 : prescale_q + 1'b1;
    index_d    = index_q;
    if (tick) begin
      index_d = (index_q == INDEX_LAST) ? '0 : index_q + 1'b1;
    end
  end

  // Hold/display transfer. A load landing on the wrap edge goes straight to
  // the display register, so it is shown in the very next frame.
  always_comb begin
    hold_d    = hold_q;
    hold_dp_d = hold_dp_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    if (wrap) begin
      if (bus.load) begin
        disp_d    = bus.data_in;
        disp_dp_d = bus.dp_in;
      end else if (pending_q) begin
        disp_d    = hold_q;
        disp_dp_d = hold_dp_q;
      end
      pending_d = 1'b0;
    end else if (bus.load) begin
      hold_d    = bus.data_in;
      hold_dp_d = bus.dp_in;
      pending_d = 1'b1;
    end
  end

  // zero_from[k] = every nibble at index >= k is zero.
  logic [DIGITS:1]   zero_from;
  logic [DIGITS-1:0] lead_blank;

  assign zero_from[DIGITS] = 1'b1;
  assign lead_blank[0]     = 1'b0;

  generate
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lead
      assign zero_from[gi]  = zero_from[gi+1] && (disp_q[4*gi +: 4] == 4'h0);
      assign lead_blank[gi] = zero_from[gi];
    end
  endgenerate

  // Select the currently scanned digit.
  logic [DIGITS-1:0] an_hot;
  logic [3:0]        nibble_sel;
  logic              dp_sel;
  logic              blank_sel;

  always_comb begin
    an_hot     = '0;
    nibble_sel = 4'h0;
    dp_sel     = 1'b0;
    blank_sel  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (index_q == IW'(k)) begin
        an_hot[k]  = 1'b1;
        nibble_sel = disp_q[4*k +: 4];
        dp_sel     = disp_dp_q[k];
        blank_sel  = bus.blank_zeros && lead_blank[k];
      end
    end
  end

  hex_to_seg7 #(
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_decode (
    .nibble_i (nibble_sel),
    .blank_i  (blank_sel),
    .seg_o    (seg_d)
  );

  // an/seg/dp all derive from the same index_q and are registered together,
  // so enable and segment data never disagree.
  always_comb begin
    an_d         = ACTIVE_LOW ? ~an_hot : an_hot;
    dp_d         = ACTIVE_LOW ? ~dp_sel : dp_sel;
    frame_done_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_q   <= '0;
      index_q      <= '0;
      hold_q       <= '0;
      hold_dp_q    <= '0;
      pending_q    <= 1'b0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      an_q         <= AN_RESET;
      seg_q        <= SEG_RESET;
      dp_q         <= DP_RESET;
      frame_done_q <= 1'b0;
    end else begin
      prescale_q   <= prescale_d;
      index_q      <= index_d;
      hold_q       <= hold_d;
      hold_dp_q    <= hold_dp_d;
      pending_q    <= pending_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed + randomized bench for seg7_scan_driver with
// REFRESH_DIV=4, ACTIVE_LOW=1 (one frame = 16 clocks). A reference model
// tracks clocks since reset and the values loaded, and predicts every output
// after every clock edge.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DATA_WIDTH(16), .DIGITS(4)) bus ();

  seg7_scan_driver #(
    .DATA_WIDTH  (16),
    .DIGITS      (4),
    .REFRESH_DIV (4),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state
  int          n;          // clock edges since reset released
  logic [15:0] disp_m, hold_m;
  logic [3:0]  ddp_m, hdp_m;
  bit          pend_m;
  bit          bz;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fd;

  int checks = 0;
  int passed = 0;

  // Active-high gfedcba hex patterns.
  function automatic logic [6:0] ref_seg(input int v);
    case (v)
      0:  return 7'b0111111;  1:  return 7'b0000110;
      2:  return 7'b1011011;  3:  return 7'b1001111;
      4:  return 7'b1100110;  5:  return 7'b1101101;
      6:  return 7'b1111101;  7:  return 7'b0000111;
      8:  return 7'b1111111;  9:  return 7'b1101111;
      10: return 7'b1110111;  11: return 7'b1111100;
      12: return 7'b0111001;  13: return 7'b1011110;
      14: return 7'b1111001;  default: return 7'b1110001;
    endcase
  endfunction

  task automatic check_outputs();
    checks++;
    assert (bus.an === exp_an) passed++;
    else $error("FAIL an: observed %b expected %b (n=%0d)", bus.an, exp_an, n);
    checks++;
    assert (bus.seg === exp_seg) passed++;
    else $error("FAIL seg: observed %b expected %b (n=%0d)", bus.seg, exp_seg, n);
    checks++;
    assert (bus.dp === exp_dp) passed++;
    else $error("FAIL dp: observed %b expected %b (n=%0d)", bus.dp, exp_dp, n);
    checks++;
    assert (bus.frame_done === exp_fd) passed++;
    else $error("FAIL frame_done: observed %b expected %b (n=%0d)", bus.frame_done, exp_fd, n);
  endtask

  // One clock: drive inputs, advance the model across the edge, check outputs.
  task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] dpv, input bit rst);
    int          digit;
    logic [15:0] upper;
    bit          blanked;
    reset           = rst;
    bus.load        = ld;
    bus.data_in     = d;
    bus.dp_in       = dpv;
    bus.blank_zeros = bz;
    @(posedge clk);
    if (rst) begin
      n = 0; disp_m = '0; ddp_m = '0; hold_m = '0; hdp_m = '0; pend_m = 0;
      exp_an = 4'b1110; exp_seg = 7'b1000000; exp_dp = 1'b1; exp_fd = 1'b0;
    end else begin
      // Outputs after this edge show the digit scanned before it.
      digit   = (n / 4) % 4;
      upper   = disp_m >> (4 * digit);
      blanked = bz && (digit != 0) && (upper == 16'h0);
      exp_seg = ~(blanked ? 7'b0 : ref_seg(int'(upper[3:0])));
      exp_an  = 4'b1111;
      exp_an[digit] = 1'b0;
      exp_dp  = ~ddp_m[digit];
      n++;
      exp_fd  = (n % 16 == 0);
      if (n % 16 == 0) begin
        if (ld) begin
          disp_m = d; ddp_m = dpv;
        end else if (pend_m) begin
          disp_m = hold_m; ddp_m = hdp_m;
        end
        pend_m = 0;
      end else if (ld) begin
        hold_m = d; hdp_m = dpv; pend_m = 1;
      end
    end
    @(negedge clk);
    check_outputs();
    $display("step n=%0d ld=%0b d=%h rst=%0b an=%b seg=%b dp=%b fd=%b",
             n, ld, d, rst, bus.an, bus.seg, bus.dp, bus.frame_done);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 16'h0, 4'h0, 0);
  endtask

  // Idle until the model's frame phase equals 'phase' (bounded to one frame).
  task automatic run_to(input int phase);
    for (int i = 0; i < 16 && (n % 16) != phase; i++) step(0, 16'h0, 4'h0, 0);
    checks++;
    assert ((n % 16) == phase) passed++;
    else $error("FAIL run_to: observed phase %0d expected %0d", n % 16, phase);
  endtask

  initial begin
    bz = 0;
    n = 0;
    reset = 1'b1;
    bus.load = 1'b0; bus.data_in = '0; bus.dp_in = '0; bus.blank_zeros = 1'b0;

    // 1. Reset, then scan of digits and first frame_done.
    step(0, 16'h0, 4'h0, 1);
    step(0, 16'h0, 4'h0, 1);
    step(0, 16'h0, 4'h0, 1);
    idle(20);

    // 2. Mid-frame load of BEEF shows only from the next frame on.
    run_to(6);
    step(1, 16'hBEEF, 4'h0, 0);
    idle(40);

    // 3. Leading-zero blanking on and off.
    bz = 1;
    step(1, 16'h0040, 4'h0, 0);
    idle(36);
    bz = 0;
    idle(20);

    // 4. Two loads in one frame: last write wins.
    run_to(2);
    step(1, 16'h1111, 4'h0, 0);
    idle(2);
    step(1, 16'h2222, 4'h0, 0);
    idle(36);

    // 5. Load on the exact wrap edge bypasses into the display register.
    run_to(15);
    step(1, 16'h00A5, 4'b0001, 0);
    idle(20);

    // 6. Reset while BEEF is on digit 2.
    step(1, 16'hBEEF, 4'h0, 0);
    run_to(0);
    run_to(10);
    step(0, 16'h0, 4'h0, 1);
    idle(20);

    // Randomized traffic, including loads on boundaries and blanking toggles.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) bz = ~bz;
      step($urandom_range(0, 5) == 0,
           ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom),
           4'($urandom),
           $urandom_range(0, 199) == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
